// File: rtl/pat_busy_sched.sv
// -----------------------------------------------------------------------------
// pat_busy_sched
//
// Pattern busy scheduler. Picks up the best pattern reported by a 1-of-N
// sorter. If the pattern passes the hit threshold and is not busy, the
// scheduler accepts it. Each accept issues a one-clock trigger. It also marks a
// window of keys around the accepted key as busy for HOLD clocks, so the sorter
// skips that window on later picks.
//
// Optional feature (compile-time macro PAT_BSY_EXT_MASK_EN):
//   Adds input bsy_ext, a static dead-key mask ORed into bsy. This mask never
//   touches the hold counters.
//
// Ports
//   clock      : sole clock
//   reset_n    : synchronous, active-low reset
//   run        : enables acceptance of new patterns
//   hit_thresh : minimum hit count (best_pat[6:4]) for acceptance
//   best_pat   : best pattern from sorter {hits[2:0], id[3:0]}
//   best_key   : key number of best_pat
//   best_bsy   : sorter winner is already busy
//   bsy_ext    : (PAT_BSY_EXT_MASK_EN only) static per-key dead mask
//   bsy        : per-key busy mask back to the sorter
//   trig       : one-clock accept pulse
//   trig_key   : key of the most recent accept
//   trig_pat   : pattern of the most recent accept
//   trig_cnt   : saturating count of accepts
// -----------------------------------------------------------------------------
module pat_busy_sched #(
    parameter int MXKEY  = 32,
    parameter int MXKEYB = 5,
    parameter int MXPATB = 7,
    parameter int SPREAD = 2,
    parameter int HOLD   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              run,
    input  logic [2:0]        hit_thresh,
    input  logic [MXPATB-1:0] best_pat,
    input  logic [MXKEYB-1:0] best_key,
    input  logic              best_bsy,
`ifdef PAT_BSY_EXT_MASK_EN
    input  logic [MXKEY-1:0]  bsy_ext,
`endif
    output logic [MXKEY-1:0]  bsy,
    output logic              trig,
    output logic [MXKEYB-1:0] trig_key,
    output logic [MXPATB-1:0] trig_pat,
    output logic [15:0]       trig_cnt
);

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] BLANK  = 1'b1;

    localparam logic [3:0] HOLD_V = 4'(HOLD);

    logic [0:0]       state;
    logic [3:0]       hold_cnt [MXKEY];
    logic [MXKEY-1:0] cnt_bsy;
    logic [MXKEY-1:0] load;
    logic [2:0]       best_hits;
    logic             accept;
    int               win_lo;
    int               win_hi;

    assign best_hits = best_pat[MXPATB-1 -: 3];

    // In BLANK, the sorter output still reflects the state before the last
    // accept, so it is ignored.
    assign accept = (state == SEARCH) && run && !best_bsy && (best_hits >= hit_thresh);

    // Load window is best_key +/- SPREAD. The loop bounds clip it at 0 and
    // MXKEY-1, so the window never wraps to the other end.
    // NOTE: every signal driven in always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        load   = '0;
        win_lo = int'(best_key) - SPREAD;
        win_hi = int'(best_key) + SPREAD;
        for (int k = 0; k < MXKEY; k++) begin
            load[k] = accept && (k >= win_lo) && (k <= win_hi);
        end
    end

    always_comb begin
        cnt_bsy = '0;
        for (int k = 0; k < MXKEY; k++) begin
            cnt_bsy[k] = (hold_cnt[k] != 4'd0);
        end
    end

`ifdef PAT_BSY_EXT_MASK_EN
    assign bsy = cnt_bsy | bsy_ext;
`else
    assign bsy = cnt_bsy;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= SEARCH;
            trig     <= 1'b0;
            trig_key <= '0;
            trig_pat <= '0;
            trig_cnt <= '0;
            // NOTE: the hold counters are an array, but they are real state
            // that must be cleared mid-hold, so they are reset like any
            // other register.
            for (int k = 0; k < MXKEY; k++) begin
                hold_cnt[k] <= 4'd0;
            end
        end else begin
            case (state)
                SEARCH:  if (accept) state <= BLANK;
                BLANK:   state <= SEARCH;
                default: state <= SEARCH;
            endcase

            trig <= accept;
            if (accept) begin
                trig_key <= best_key;
                trig_pat <= best_pat;
                if (trig_cnt != 16'hFFFF) begin
                    trig_cnt <= trig_cnt + 16'd1;
                end
            end

            // A load takes priority over the decrement. It restarts a running
            // hold at HOLD and never adds to it.
            for (int k = 0; k < MXKEY; k++) begin
                if (load[k]) begin
                    hold_cnt[k] <= HOLD_V;
                end else if (hold_cnt[k] != 4'd0) begin
                    hold_cnt[k] <= hold_cnt[k] - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pat_busy_sched.sv
// -----------------------------------------------------------------------------
// tb_pat_busy_sched
//
// Self-checking bench for pat_busy_sched. A behavioural reference model keeps
// one "clocks remaining" integer per key, a blank flag and the trigger
// registers. Each clock it updates them from the scheduler rules. The bench
// checks the DUT against this model on every clock, and also checks a table of
// hand-derived accept/reject vectors and directed corner sequences.
// -----------------------------------------------------------------------------
module tb_pat_busy_sched;

    localparam int NKEY = 32;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run;
    logic [2:0]  hit_thresh;
    logic [6:0]  best_pat;
    logic [4:0]  best_key;
    logic        best_bsy;
    logic [31:0] bsy_ext_v = 32'h0;
`ifdef PAT_BSY_EXT_MASK_EN
    logic [31:0] bsy_ext;
    assign bsy_ext = bsy_ext_v;
`endif
    logic [31:0] bsy;
    logic        trig;
    logic [4:0]  trig_key;
    logic [6:0]  trig_pat;
    logic [15:0] trig_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_busy [NKEY];
    bit m_blank;
    bit m_trig;
    int m_key;
    int m_pat;
    int m_cnt;

    pat_busy_sched dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .hit_thresh (hit_thresh),
        .best_pat   (best_pat),
        .best_key   (best_key),
        .best_bsy   (best_bsy),
`ifdef PAT_BSY_EXT_MASK_EN
        .bsy_ext    (bsy_ext),
`endif
        .bsy        (bsy),
        .trig       (trig),
        .trig_key   (trig_key),
        .trig_pat   (trig_pat),
        .trig_cnt   (trig_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update for one rising edge, using the inputs present before the edge.
    task automatic model_edge();
        bit acc;
        int hits;
        if (!reset_n) begin
            foreach (m_busy[k]) m_busy[k] = 0;
            m_blank = 0;
            m_trig  = 0;
            m_key   = 0;
            m_pat   = 0;
            m_cnt   = 0;
        end else begin
            hits = int'(best_pat) / 16;
            acc  = !m_blank && run && !best_bsy && (hits >= int'(hit_thresh));
            foreach (m_busy[k]) if (m_busy[k] > 0) m_busy[k] = m_busy[k] - 1;
            if (acc) begin
                for (int k = int'(best_key) - 2; k <= int'(best_key) + 2; k++) begin
                    if (k >= 0 && k < NKEY) m_busy[k] = 8;
                end
                m_key = int'(best_key);
                m_pat = int'(best_pat);
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            m_trig  = acc;
            m_blank = acc;
        end
    endtask

    function automatic logic [31:0] model_bsy();
        logic [31:0] e;
        e = '0;
        for (int k = 0; k < NKEY; k++) e[k] = (m_busy[k] > 0);
`ifdef PAT_BSY_EXT_MASK_EN
        e = e | bsy_ext_v;
`endif
        return e;
    endfunction

    // One clock: update the model at the edge, then compare 1 ns later.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("trig",     32'(trig),     32'(m_trig));
        check("trig_key", 32'(trig_key), 32'(m_key));
        check("trig_pat", 32'(trig_pat), 32'(m_pat));
        check("trig_cnt", 32'(trig_cnt), 32'(m_cnt));
        check("bsy",      bsy,           model_bsy());
    endtask

    task automatic drive(input logic r, input logic [2:0] th, input logic [6:0] p,
                         input logic [4:0] k, input logic b);
        run        = r;
        hit_thresh = th;
        best_pat   = p;
        best_key   = k;
        best_bsy   = b;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'd0, 7'h0, 5'd0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic       run;
        logic [2:0] th;
        logic [6:0] pat;
        logic [4:0] key;
        logic       bbsy;
        logic       exp_trig;
    } vec_t;

    vec_t vecs [10];

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 3'd0, 7'h0, 5'd0, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        idle(2);

        // ---- table-driven accept / reject vectors ----
        vecs[0] = '{1'b1, 3'd4, 7'h61, 5'd10, 1'b0, 1'b1}; // basic accept
        vecs[1] = '{1'b1, 3'd4, 7'h3A, 5'd10, 1'b0, 1'b0}; // hits 3 < 4
        vecs[2] = '{1'b1, 3'd4, 7'h61, 5'd10, 1'b1, 1'b0}; // winner busy
        vecs[3] = '{1'b0, 3'd4, 7'h61, 5'd10, 1'b0, 1'b0}; // run off
        vecs[4] = '{1'b1, 3'd0, 7'h05, 5'd0,  1'b0, 1'b1}; // zero thresh, zero hits
        vecs[5] = '{1'b1, 3'd7, 7'h7F, 5'd31, 1'b0, 1'b1}; // max hits at max thresh
        vecs[6] = '{1'b1, 3'd7, 7'h6F, 5'd31, 1'b0, 1'b0}; // 6 < 7
        vecs[7] = '{1'b1, 3'd3, 7'h3A, 5'd20, 1'b0, 1'b1}; // equal to thresh
        vecs[8] = '{1'b1, 3'd1, 7'h1C, 5'd3,  1'b1, 1'b0}; // busy overrides pass
        vecs[9] = '{1'b1, 3'd5, 7'h52, 5'd17, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].run, vecs[i].th, vecs[i].pat, vecs[i].key, vecs[i].bbsy);
            step();
            check("vec_trig", 32'(trig), 32'(vecs[i].exp_trig));
            if (vecs[i].exp_trig) check("vec_key", 32'(trig_key), 32'(vecs[i].key));
            idle(2);
        end
        idle(10);

        // ---- key 10, window 12:8 busy for exactly 8 clocks ----
        drive(1'b1, 3'd4, 7'h61, 5'd10, 1'b0);
        step();
        check("s34_trig", 32'(trig), 32'h1);
        check("s34_key",  32'(trig_key), 32'd10);
        drive(1'b0, 3'd4, 7'h61, 5'd10, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("s34_bsy_on", bsy, 32'h0000_1F00);
            if (i < 7) step();
        end
        step();
        check("s34_bsy_off", bsy, 32'h0);
        idle(2);

        // ---- edge clipping at key 0 and key 31 ----
        drive(1'b1, 3'd1, 7'h11, 5'd0, 1'b0);
        step();
        check("s35_lo", bsy, 32'h0000_0007);
        idle(1);
        drive(1'b1, 3'd1, 7'h11, 5'd31, 1'b0);
        step();
        check("s35_hi", bsy, 32'hE000_0007);
        idle(10);
        check("s35_clear", bsy, 32'h0);

        // ---- constant valid pattern: trig every other clock ----
        drive(1'b1, 3'd2, 7'h25, 5'd5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("s36_pulse", 32'(trig), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        idle(10);

        // ---- reset three clocks after an accept ----
        drive(1'b1, 3'd4, 7'h61, 5'd10, 1'b0);
        step();
        idle(3);
        reset_n = 1'b0;
        drive(1'b1, 3'd4, 7'h61, 5'd10, 1'b0);   // coincident accept is dropped
        step();
        check("s38_bsy", bsy, 32'h0);
        check("s38_cnt", 32'(trig_cnt), 32'h0);
        check("s38_trig", 32'(trig), 32'h0);
        reset_n = 1'b1;
        idle(2);

`ifdef PAT_BSY_EXT_MASK_EN
        bsy_ext_v = 32'h0000_0001;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("s39_ext", bsy, 32'h0000_0001);
        end
        bsy_ext_v = 32'h0;
        idle(1);
`endif

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 4) == 0));
`ifdef PAT_BSY_EXT_MASK_EN
            if (i % 100 == 0) bsy_ext_v = $urandom;
`endif
            step();
        end
        reset_n = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pat_busy_sched.md
PAT_BUSY_SCHED -- requirements
Module: pat_busy_sched

Interface
REQ-001 SHALL have parameter MXKEY, default 32, number of 1/2-strip keys.
REQ-002 SHALL have parameter MXKEYB, default 5, key number width.
REQ-003 SHALL have parameter MXPATB, default 7, pattern width (bits 6:4 hit count, bits 3:0 pattern id).
REQ-004 SHALL have parameter SPREAD, default 2, keys blocked on each side of an accepted key.
REQ-005 SHALL have parameter HOLD, default 8, busy hold time in clocks (1..15).
REQ-006 SHALL have port clock, input, 1, sole clock.
REQ-007 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-008 SHALL have port run, input, 1, enables acceptance of new patterns.
REQ-009 SHALL have port hit_thresh, input, 3, minimum hit count for acceptance.
REQ-010 SHALL have port best_pat, input, MXPATB, best pattern from the 1-of-32 sorter.
REQ-011 SHALL have port best_key, input, MXKEYB, key of best_pat.
REQ-012 SHALL have port best_bsy, input, 1, sorter winner is busy.
REQ-013 SHALL have port bsy, output, MXKEY, per-key busy mask driven to the sorter.
REQ-014 SHALL have port trig, output, 1, one-clock accept pulse.
REQ-015 SHALL have port trig_key, output, MXKEYB, accepted key.
REQ-016 SHALL have port trig_pat, output, MXPATB, accepted pattern.
REQ-017 SHALL have port trig_cnt, output, 16, saturating count of accepts.

Function
REQ-018 SHALL implement a two-state FSM: SEARCH and BLANK.
REQ-019 In SEARCH, a candidate SHALL be accepted when run=1, best_bsy=0, and best_pat[6:4] >= hit_thresh.
REQ-020 On acceptance at edge N, the block SHALL, at edge N+1 (registered, one-clock latency):
- assert trig for exactly one clock;
- load trig_key and trig_pat;
- increment trig_cnt;
- enter BLANK.
REQ-021 BLANK SHALL last exactly one clock, ignoring inputs (sorter output is stale by its one pipeline stage), then return to SEARCH.
REQ-022 Each key k SHALL own a 4-bit down-counter; bsy[k]=1 while its counter is nonzero.
REQ-023 On acceptance, counters for keys best_key-SPREAD .. best_key+SPREAD SHALL load HOLD at the same edge trig asserts.
REQ-024 The load window SHALL be clipped at key 0 and key MXKEY-1, with no wrap-around.
REQ-025 Nonzero counters outside a load SHALL decrement by 1 per clock; a load overrides a decrement in the same clock (reload to HOLD, never extended beyond HOLD).
REQ-026 trig_key and trig_pat SHALL hold their value until the next accept.
REQ-027 trig_cnt SHALL saturate at 16'hFFFF.
REQ-028 When run=0, no new accepts SHALL occur; existing counters SHALL continue to decrement.
REQ-029 An accept candidate with best_bsy=1 SHALL be rejected even if the hit count passes.

Reset
REQ-030 When reset_n=0 at a clock edge, the block SHALL set state=SEARCH, all counters=0, bsy=0, trig=0, trig_key=0, trig_pat=0, trig_cnt=0.
REQ-031 Reset mid-hold SHALL clear all busy immediately at that edge; an acceptance coincident with reset SHALL be discarded.

Configuration
REQ-032 With macro PAT_BSY_EXT_MASK_EN defined, the block SHALL add input bsy_ext[MXKEY-1:0] (static dead-key mask), with bsy = counter busy OR bsy_ext, and bsy_ext SHALL NOT affect the counters.
REQ-033 Without PAT_BSY_EXT_MASK_EN, the bsy_ext port SHALL be absent and bsy SHALL equal the counter busy only.

Verification
REQ-034 Scenario: best_pat=7'h61, best_key=10, thresh=4, run=1 -> trig=1 next clock; trig_key=10; bsy[12:8]=1 for 8 clocks; then bsy=0.
REQ-035 Scenario: accept at key 0, then at key 31 -> bsy[2:0] set, then bsy[31:29] set; no wrap bits set.
REQ-036 Scenario: valid pattern held constant at key 5 -> trig pulses separated by at least 2 clocks; the clock after each trig is BLANK with no trig.
REQ-037 Scenario: best_pat hits=3, thresh=4; or best_bsy=1; or run=0 -> no trig; trig_cnt unchanged.
REQ-038 Scenario: accept key 10, reset_n=0 three clocks later -> bsy=0 and trig_cnt=0 the next clock.
REQ-039 Scenario: with PAT_BSY_EXT_MASK_EN and bsy_ext=32'h0000_0001, no accepts -> bsy=32'h0000_0001 constant.
